// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_rx_fifo_pkg
//   Shared constants, frame FSM state encoding and frame-check helper for the
//   PS/2 receive path.
//   Frame layout once fully shifted in (bit 0 received first):
//     [0] start, [8:1] data LSB-first, [9] odd parity, [10] stop.
package ps2_rx_fifo_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_t;

    // A frame is good when start is 0, stop is 1 and data plus parity hold an
    // odd number of ones.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && (f[PS2_FRAME_BITS-1] == 1'b1) && (^f[PS2_FRAME_BITS-2:1]);
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if
//   Consumer-side bundle of the PS/2 receiver.
//   data        head scan-code byte (receiver -> consumer)
//   valid       FIFO not empty       (receiver -> consumer)
//   ready       consumer takes head  (consumer -> receiver)
//   overflow    sticky drop flag     (receiver -> consumer)
//   parity_err  sticky framing flag  (receiver -> consumer)
//   clr_err     clears both flags    (consumer -> receiver)
interface ps2_rx_fifo_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       overflow;
    logic       parity_err;
    logic       clr_err;

    modport master (
        output data, valid, overflow, parity_err,
        input  ready, clr_err
    );

    modport slave (
        input  data, valid, overflow, parity_err,
        output ready, clr_err
    );

endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with power-of-two depth.
//   clk, rst   clock and asynchronous active-low reset
//   push/wdata write request and byte; honoured when not full or popping
//   pop        read request; ignored when empty
//   rdata      entry at the head (registered storage, holds when empty)
//   full/empty occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a full ring from an empty one.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 keyboard receiver: synchronises the raw ps2_clk/ps2_data pins,
//   deframes 11-bit frames and queues good scan-code bytes in a FIFO that the
//   consumer drains with valid/ready.
//   clk       system clock
//   rst       asynchronous active-low reset
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_data  raw PS/2 data pin (asynchronous)
//   bus       consumer handshake and sticky error flags (ps2_rx_fifo_if)
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_rx_fifo_if.master   bus
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [2:0]                clk_sync;
    logic [2:0]                data_sync;
    logic                      strobe;
    logic                      bit_in;
    ps2_state_t                state;
    logic [3:0]                bit_cnt;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic [TW-1:0]             idle_cnt;
    logic                      push_req;
    logic                      parity_err_q;
    logic                      overflow_q;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [PS2_DATA_BITS-1:0]  fifo_rdata;

    // Pins are idle-high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign strobe = clk_sync[2] && !clk_sync[1];
    assign bit_in = data_sync[1];

    // Frame FSM. Bits shift in from the top so the start bit ends up in
    // frame[0] once all eleven have arrived. The push request is registered,
    // so a good byte reaches the FIFO the cycle after CHECK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            frame        <= '0;
            idle_cnt     <= '0;
            push_req     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (bus.clr_err) begin
                parity_err_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    bit_cnt  <= '0;
                    if (strobe && !bit_in) begin
                        frame   <= {bit_in, frame[PS2_FRAME_BITS-1:1]};
                        bit_cnt <= 4'd1;
                        state   <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (strobe) begin
                        frame    <= {bit_in, frame[PS2_FRAME_BITS-1:1]};
                        idle_cnt <= '0;
                        if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                            state <= ST_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state    <= ST_IDLE;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    if (frame_ok(frame)) begin
                        push_req <= 1'b1;
                    end else begin
                        parity_err_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_pop = bus.ready && !fifo_empty;

    // A good byte is dropped only when the FIFO is full and nothing leaves
    // in the same cycle; a new drop beats a concurrent clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_err) begin
            overflow_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (frame[PS2_DATA_BITS:1]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.data       = fifo_rdata;
    assign bus.valid      = !fifo_empty;
    assign bus.overflow   = overflow_q;
    assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
//   Bench for ps2_rx_fifo: bit-bangs PS/2 frames onto the pins and compares
//   the consumer side against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int DEPTH       = 8;
    localparam int TIMEOUT_CYC = 1024;
    localparam int HALF        = 10;

    logic clk;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.master)
    );

    int         assert_count = 0;
    int         fail_count   = 0;
    logic [7:0] model_q[$];
    logic       model_ovf;
    logic       model_perr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so the run always ends even if the design wedges.
    initial begin
        #3000000;
        fail_count++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Frame for byte b: odd parity, optional corrupted parity or stop bit.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    // Drives the first nbits of a frame. mode 1 checks valid latency around
    // the stop edge; mode 2 raises ready exactly in the cycle the byte is pushed.
    task automatic applyStimulus(input logic [10:0] f, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (4) @(posedge clk);
                #1 checkOutput("latency_4clk_valid", bus.valid, 0);
                @(posedge clk);
                #1 checkOutput("latency_5clk_valid", bus.valid, 1);
            end else if (i == 10 && mode == 2) begin
                repeat (4) @(negedge clk);
                bus.ready = 1'b1;
                @(negedge clk);
                bus.ready = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Full frame plus model update for an ordinary (no pop) delivery.
    task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        applyStimulus(make_frame(b, flip_par, bad_stop), 11, 0);
        if (flip_par || bad_stop) begin
            model_perr = 1'b1;
        end else if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        exp = model_q.pop_front();
        checkOutput({tag, "_valid"}, bus.valid, 1);
        checkOutput({tag, "_data"}, bus.data, exp);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic clear_errors();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        model_ovf  = 1'b0;
        model_perr = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        checkOutput({tag, "_overflow"}, bus.overflow, model_ovf);
        checkOutput({tag, "_parity_err"}, bus.parity_err, model_perr);
        checkOutput({tag, "_valid"}, bus.valid, model_q.size() != 0);
    endtask

    task automatic drain(input string tag);
        while (model_q.size() != 0) begin
            pop_one(tag);
        end
        checkOutput({tag, "_empty"}, bus.valid, 0);
    endtask

    initial begin
        rst         = 1'b0;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        bus.ready   = 1'b0;
        bus.clr_err = 1'b0;
        model_ovf   = 1'b0;
        model_perr  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", bus.valid, 0);
        checkOutput("reset_data", bus.data, 8'h00);
        checkOutput("reset_overflow", bus.overflow, 0);
        checkOutput("reset_parity_err", bus.parity_err, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame, then a clean frame.
        applyStimulus(make_frame(8'hAA, 0, 0), 5, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_valid", bus.valid, 0);
        checkOutput("midreset_flags", {bus.overflow, bus.parity_err}, 0);
        ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h1C, 0, 0);
        check_flags("after_reset");
        drain("after_reset_pop");

        // Latency from stop edge, then a one-cycle ready pulse.
        applyStimulus(make_frame(8'h1C, 0, 0), 11, 1);
        model_q.push_back(8'h1C);
        pop_one("latency_pop");
        checkOutput("ready_pulse_valid", bus.valid, 0);

        // Bad parity is dropped and flagged; clr_err clears it.
        send_byte(8'h1C, 1, 0);
        check_flags("bad_parity");
        clear_errors();
        check_flags("clr_parity");

        // Nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) begin
            send_byte(8'(i), 0, 0);
        end
        check_flags("overflow");
        drain("overflow_pop");
        clear_errors();
        check_flags("clr_overflow");

        // Stalled partial frame is discarded silently after the timeout.
        applyStimulus(make_frame(8'h33, 0, 0), 5, 0);
        repeat (TIMEOUT_CYC + 4) @(negedge clk);
        send_byte(8'hF0, 0, 0);
        check_flags("timeout");
        drain("timeout_pop");

        // Full FIFO with a pop landing on the same cycle as the push.
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'($urandom_range(0, 255)), 0, 0);
        end
        applyStimulus(make_frame(8'h5A, 0, 0), 11, 2);
        void'(model_q.pop_front());
        model_q.push_back(8'h5A);
        check_flags("push_pop_full");
        drain("push_pop_full_pop");

        // Random frames, corruptions, pops and clears.
        for (int n = 0; n < 24; n++) begin
            int kind;
            int npop;
            kind = $urandom_range(0, 5);
            send_byte(8'($urandom_range(0, 255)), kind == 0, kind == 1);
            check_flags("rand");
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop && model_q.size() != 0; k++) begin
                pop_one("rand_pop");
            end
            if ($urandom_range(0, 3) == 0) begin
                clear_errors();
                check_flags("rand_clr");
            end
        end
        drain("final_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
